// File: rtl/pes_traffic_pkg.sv
// Shared definitions for the junction traffic arbiter: light codes, FSM states
// and default phase timings.
package pes_traffic_pkg;

    localparam int DEF_MIN_GREEN   = 8;
    localparam int DEF_MAX_GREEN   = 32;
    localparam int DEF_YELLOW_TIME = 3;
    localparam int DEF_ALLRED_TIME = 2;

    localparam logic [2:0]  LIGHT_RED    = 3'b100;
    localparam logic [2:0]  LIGHT_YELLOW = 3'b010;
    localparam logic [2:0]  LIGHT_GREEN  = 3'b001;
    localparam logic [11:0] ALL_RED      = {4{LIGHT_RED}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } state_t;

    // All approaches RED except approach id, which shows color.
    function automatic logic [11:0] light_word(input logic [1:0] id, input logic [2:0] color);
        logic [11:0] w;
        w = ALL_RED;
        case (id)
            2'd0:    w[2:0]  = color;
            2'd1:    w[5:3]  = color;
            2'd2:    w[8:6]  = color;
            default: w[11:9] = color;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pes_rr_pick.sv
// Rotating-priority pick: the first requesting approach at or after ptr,
// wrapping modulo 4.
module pes_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] pick,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        pick = ptr;
        idx  = ptr;
        any  = |req;
        // Scan farthest offset first so the nearest requester overwrites it.
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/pes_junction_arbiter.sv
// Four-approach traffic junction arbiter: rotating grant, minimum/maximum
// green, fixed yellow and all-red clearance. All outputs are registered.
module pes_junction_arbiter
    import pes_traffic_pkg::*;
#(
    parameter int MIN_GREEN   = DEF_MIN_GREEN,
    parameter int MAX_GREEN   = DEF_MAX_GREEN,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int ALLRED_TIME = DEF_ALLRED_TIME
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    output logic [11:0] lights,
    output logic        grant_valid,
    output logic [1:0]  grant_id,
    output state_t      state_dbg
);

    localparam int TW = $clog2(MAX_GREEN + 1);

    localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] MAX_SAT  = TW'(MAX_GREEN);
    localparam logic [TW-1:0] Y_LAST   = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] A_LAST   = TW'(ALLRED_TIME - 1);

    state_t      state;
    logic [1:0]  ptr;
    logic [TW-1:0] timer;

    logic [1:0]  pick;
    logic        any;
    logic        own_req;
    logic        other_req;
    logic        end_green;

    pes_rr_pick u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

    assign own_req   = req[grant_id];
    assign other_req = |(req & ~(4'b0001 << grant_id));
    assign end_green = (!own_req && (timer >= MIN_LAST)) ||
                       (own_req && other_req && (timer == MAX_LAST));
    assign state_dbg = state;

    // Handshake-free block: req is a level, sampled only in GREEN and at the
    // IDLE / last-ALLRED selection edges; everything else ignores it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lights      <= ALL_RED;
            grant_valid <= 1'b0;
            grant_id    <= 2'd0;
            ptr         <= 2'd0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (any) begin
                        state       <= GREEN;
                        grant_id    <= pick;
                        grant_valid <= 1'b1;
                        lights      <= light_word(pick, LIGHT_GREEN);
                    end
                end
                GREEN: begin
                    if (end_green) begin
                        state  <= YELLOW;
                        lights <= light_word(grant_id, LIGHT_YELLOW);
                        timer  <= '0;
                    end else if (timer != MAX_SAT) begin
                        timer <= timer + 1'b1;
                    end
                end
                YELLOW: begin
                    if (timer == Y_LAST) begin
                        state       <= ALLRED;
                        lights      <= ALL_RED;
                        grant_valid <= 1'b0;
                        ptr         <= grant_id + 2'd1;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    if (timer == A_LAST) begin
                        timer <= '0;
                        if (any) begin
                            state       <= GREEN;
                            grant_id    <= pick;
                            grant_valid <= 1'b1;
                            lights      <= light_word(pick, LIGHT_GREEN);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pes_junction_arbiter.sv
// Bench for pes_junction_arbiter: phase-segment table plus hand sequences for
// reset corner cases; expected outputs flow through a scoreboard queue.
module tb_pes_junction_arbiter;
    import pes_traffic_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] lights;
    logic        grant_valid;
    logic [1:0]  grant_id;
    state_t      state_dbg;

    int total;
    int bad;

    typedef struct {
        int         tag;
        logic [3:0] req;
        int         n;
        logic [11:0] lights;
        logic       valid;
        logic [1:0] id;
    } seg_t;

    seg_t segs[$];
    logic [14:0] exp_q[$];

    pes_junction_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .lights      (lights),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .state_dbg   (state_dbg)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] lw(input int id, input logic [2:0] color);
        logic [11:0] w;
        w = 12'h924;
        w[3*id +: 3] = color;
        return w;
    endfunction

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got lights=%h valid=%b id=%0d, want lights=%h valid=%b id=%0d",
                     name, got[14:3], got[2], got[1:0], exp[14:3], exp[2], exp[1:0]);
        end
    endtask

    task automatic add(input int tag, input logic [3:0] r, input int n,
                       input logic [11:0] l, input logic v, input logic [1:0] id);
        seg_t s;
        s.tag = tag; s.req = r; s.n = n; s.lights = l; s.valid = v; s.id = id;
        segs.push_back(s);
    endtask

    // driver + scoreboard: push expectation with the drive, pop after the edge
    task automatic run_scenario(input int tag);
        logic [14:0] exp;
        foreach (segs[i]) begin
            if (segs[i].tag == tag) begin
                for (int c = 0; c < segs[i].n; c++) begin
                    @(negedge clk);
                    req = segs[i].req;
                    exp_q.push_back({segs[i].lights, segs[i].valid, segs[i].id});
                    @(posedge clk);
                    #1;
                    exp = exp_q.pop_front();
                    check($sformatf("scn%0d_seg%0d_cyc%0d", tag, i, c),
                          {lights, grant_valid, grant_id}, exp);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {lights, grant_valid, grant_id}, {12'h924, 1'b0, 2'd0});
        total++;
        if (state_dbg !== IDLE) begin
            bad++;
            $display("FAIL %s_state: got %0d want %0d", name, state_dbg, IDLE);
        end
    endtask

    initial begin
        int order [8];
        total = 0;
        bad   = 0;

        // ---- vector table ----
        add(0, 4'h0, 2, 12'h924, 1'b0, 2'd0);
        // single-cycle pulse on approach 0
        add(1, 4'h1, 1, lw(0, LIGHT_GREEN),  1'b1, 2'd0);
        add(1, 4'h0, 7, lw(0, LIGHT_GREEN),  1'b1, 2'd0);
        add(1, 4'h0, 3, lw(0, LIGHT_YELLOW), 1'b1, 2'd0);
        add(1, 4'h0, 2, 12'h924,             1'b0, 2'd0);
        add(1, 4'h0, 4, 12'h924,             1'b0, 2'd0);
        // uncontested hold on approach 2 (ptr=1 here)
        add(2, 4'h4, 210, 12'h864, 1'b1, 2'd2);
        add(2, 4'h0, 3,   12'h8A4, 1'b1, 2'd2);
        add(2, 4'h0, 2,   12'h924, 1'b0, 2'd2);
        add(2, 4'h0, 3,   12'h924, 1'b0, 2'd2);
        // contention: approach 1 joins at green cycle 2
        add(3, 4'h1, 2,  12'h921, 1'b1, 2'd0);
        add(3, 4'h3, 30, 12'h921, 1'b1, 2'd0);
        add(3, 4'h3, 3,  12'h922, 1'b1, 2'd0);
        add(3, 4'h3, 2,  12'h924, 1'b0, 2'd0);
        add(3, 4'h3, 1,  12'h90C, 1'b1, 2'd1);
        add(3, 4'h0, 7,  12'h90C, 1'b1, 2'd1);
        add(3, 4'h0, 3,  12'h914, 1'b1, 2'd1);
        add(3, 4'h0, 2,  12'h924, 1'b0, 2'd1);
        add(3, 4'h0, 2,  12'h924, 1'b0, 2'd1);
        // all requesting: full rotation twice, stopping in yellow of 3
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int j = 0; j < 8; j++) begin
            add(4, 4'hF, 32, lw(order[j], LIGHT_GREEN), 1'b1, 2'(order[j]));
            if (j < 7) begin
                add(4, 4'hF, 3, lw(order[j], LIGHT_YELLOW), 1'b1, 2'(order[j]));
                add(4, 4'hF, 2, 12'h924, 1'b0, 2'(order[j]));
            end else begin
                add(4, 4'hF, 1, lw(3, LIGHT_YELLOW), 1'b1, 2'd3);
            end
        end
        add(5, 4'h0, 1, 12'h924, 1'b0, 2'd0);

        // ---- reset held with all requests ----
        rst_n = 1'b0;
        req   = 4'hF;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check_reset_outputs($sformatf("reset_hold_%0d", c));
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'h0;

        run_scenario(0);
        run_scenario(1);
        run_scenario(2);
        run_scenario(3);

        // ---- asynchronous reset mid-GREEN (ptr is 2, grant goes to 0) ----
        @(negedge clk);
        req = 4'h1;
        @(posedge clk);
        #1;
        check("mid_green_grant", {lights, grant_valid, grant_id}, {12'h921, 1'b1, 2'd0});
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_green");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'h0;
        run_scenario(5);

        run_scenario(4);

        // ---- asynchronous reset during YELLOW of approach 3 ----
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_yellow3");
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'hF;
        @(posedge clk);
        #1;
        check("post_reset_grant0", {lights, grant_valid, grant_id}, {12'h921, 1'b1, 2'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pes_junction_arbiter.md
PES_JUNCTION_ARBITER -- requirements
Module: pes_junction_arbiter

Interface
REQ-001 The block SHALL have parameter MIN_GREEN, default 8, the minimum green duration in clk cycles (at least 1).
REQ-002 The block SHALL have parameter MAX_GREEN, default 32, the maximum contested green duration in cycles (at least MIN_GREEN).
REQ-003 The block SHALL have parameter YELLOW_TIME, default 3, the yellow duration in cycles (at least 1).
REQ-004 The block SHALL have parameter ALLRED_TIME, default 2, the all-red clearance in cycles (at least 1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req, input, 4 bits: level sensor request per approach 0..3.
REQ-008 The block SHALL have port lights, output, 12 bits: 3-bit light per approach i at [3i+2:3i], encoded RED=100, YELLOW=010, GREEN=001.
REQ-009 The block SHALL have port grant_valid, output, 1 bit: high while an approach is in GREEN or YELLOW.
REQ-010 The block SHALL have port grant_id, output, 2 bits: the approach currently or last granted.

Function
REQ-011 The block SHALL drive all outputs from registers.
REQ-012 The block SHALL implement FSM states IDLE, GREEN, YELLOW and ALLRED.
REQ-013 The block SHALL show RED on every approach not granted; at most one approach is non-RED at any time.
REQ-014 In IDLE, when req is nonzero at a clock edge, the block SHALL select an approach by rotating priority starting at pointer ptr and enter GREEN at that edge, so the light is GREEN in the next cycle.
REQ-015 In GREEN, the block SHALL increment a timer each cycle, saturating at MAX_GREEN.
REQ-016 The block SHALL leave GREEN for YELLOW when the granted approach's req is low and timer is at least MIN_GREEN-1.
REQ-017 The block SHALL leave GREEN for YELLOW when the granted approach's req is high, another req is high, and timer equals MAX_GREEN-1.
REQ-018 The block SHALL stay in GREEN indefinitely while the granted approach's req is high and no other req is high.
REQ-019 The block SHALL hold YELLOW for exactly YELLOW_TIME cycles, then ALLRED for exactly ALLRED_TIME cycles.
REQ-020 On entering ALLRED, the block SHALL set ptr to grant_id+1 mod 4.
REQ-021 At the last ALLRED cycle, if req is nonzero the block SHALL select by rotating priority from ptr and enter GREEN directly; otherwise it enters IDLE.
REQ-022 The block SHALL ignore changes on req during YELLOW and ALLRED except at the selection edge.
REQ-023 The timer width SHALL be clog2(MAX_GREEN+1); the timer resets to 0 on every state entry.
REQ-024 The block SHALL not change grant_id in IDLE.

Reset
REQ-025 Asserting rst_n low SHALL immediately, without a clock, set state=IDLE, lights=12'h924 (all RED), grant_valid=0, grant_id=0, ptr=0 and timer=0.
REQ-026 Reset asserted mid-GREEN or mid-YELLOW SHALL abort the phase with no yellow or all-red sequence; after release, operation follows REQ-014.

Structure
REQ-027 Light encodings, the state enum and the default timing constants SHALL reside in shared package pes_traffic_pkg.
REQ-028 Rotating-priority selection SHALL be a combinational sub-module pes_rr_pick (inputs req[3:0] and ptr[1:0]; outputs pick[1:0] and any).

Verification (defaults)
REQ-029 rst_n=0 for 20 cycles with req=4'hF SHALL give lights=12'h924 and grant_valid=0; holding rst_n low mid-cycle SHALL clear the outputs before the next edge.
REQ-030 From IDLE, req=4'b0100 held SHALL give lights[8:6]=001 one cycle later and grant_id=2, with GREEN held for 200+ cycles.
REQ-031 A one-cycle pulse req[0] SHALL give GREEN 8 cycles, YELLOW 3, RED 2, then IDLE with all RED.
REQ-032 With req[0] held and req[1] rising at green cycle 2, approach 0 SHALL be GREEN 32 cycles, YELLOW 3, all-RED 2, then approach 1 GREEN.
REQ-033 With req=4'hF held, the block SHALL grant in the order 0,1,2,3,0, each GREEN 32 cycles, with the 5-cycle yellow/all-red gap between grants.
REQ-034 With rst_n pulsed low during YELLOW of approach 3, lights SHALL be 12'h924 asynchronously, and the next grant with req=4'hF SHALL go to approach 0.
